// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port shared by the loader and its environment.
// The slave side is the loader; the master side feeds bytes and observes memory writes.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: packs a little-endian byte stream into words and holds the core in reset until loaded.
// Optional image checksum verification is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int          NUM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          core_rst_n,
  output logic          busy,
  output logic          done,
  output logic          checksum_err
);

  localparam int WCW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS - 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, CHECK} state_t;
`else
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE} state_t;
`endif

  state_t          state;
  logic [1:0]      byte_cnt;
  logic [WCW-1:0]  word_cnt;
  logic [23:0]     wbuf;
  logic [31:0]     word_next;
  logic            hs;

  function automatic logic [31:0] word_addr(input logic [WCW-1:0] idx);
    return BASE_ADDR + (32'(idx) << 2);
  endfunction

  assign hs        = bus.byte_valid & bus.byte_ready;
  assign word_next = {bus.byte_data, wbuf};

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum;
`else
  assign checksum_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.byte_ready <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= BASE_ADDR;
      bus.imem_wdata <= '0;
      core_rst_n     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      byte_cnt       <= '0;
      word_cnt       <= '0;
      wbuf           <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum_err   <= 1'b0;
      sum            <= '0;
`endif
    end else begin
      bus.imem_we <= 1'b0;

      // Byte lanes 0..2 are staged; lane 3 completes the word directly from the bus.
      if (hs) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    wbuf[7:0]   <= bus.byte_data;
          2'd1:    wbuf[15:8]  <= bus.byte_data;
          2'd2:    wbuf[23:16] <= bus.byte_data;
          default: ;
        endcase
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= COLLECT;
            bus.byte_ready <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            core_rst_n     <= 1'b0;
            byte_cnt       <= '0;
            word_cnt       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum_err   <= 1'b0;
            sum            <= '0;
`endif
          end
        end

        COLLECT: begin
          if (hs && byte_cnt == 2'd3) begin
            state          <= WRITE;
            bus.byte_ready <= 1'b0;
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= word_addr(word_cnt);
            bus.imem_wdata <= word_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum            <= sum + word_next;
`endif
          end
        end

        WRITE: begin
          if (word_cnt == LAST_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state          <= CHECK;
            bus.byte_ready <= 1'b1;
`else
            state          <= DONE;
            busy           <= 1'b0;
            done           <= 1'b1;
            core_rst_n     <= 1'b1;
`endif
          end else begin
            word_cnt       <= word_cnt + 1'b1;
            state          <= COLLECT;
            bus.byte_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          // The trailing four bytes carry the expected sum; the core is released only on a match.
          if (hs && byte_cnt == 2'd3) begin
            state          <= DONE;
            bus.byte_ready <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b1;
            checksum_err   <= (word_next != sum);
            core_rst_n     <= (word_next == sum);
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory; the core's fetch path is the reader of that memory.
- Accepts a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit words.
- Writes each word into the instruction memory write port.
- Holds the core in reset (core_rst_n low) until the whole program image is loaded.

Parameters:
- NUM_WORDS, 256, number of 32-bit instruction words in one image (>=1).
- BASE_ADDR, 32'h0000_0000, byte address of the first word; must be 4-byte aligned.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle load request; sampled only in IDLE or DONE.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  next image byte, little-endian within each word.
- byte_ready  output  1  loader accepts byte_data this cycle.
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  32  byte address of the word being written.
- imem_wdata  output  32  assembled word.
- core_rst_n  output  1  active-low reset to the core; low until the load completes.
- busy  output  1  high in COLLECT and WRITE.
- done  output  1  high in DONE.
- checksum_err  output  1  checksum mismatch flag (see Optional Feature).

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low.
- Reset values: state=IDLE, byte_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_rst_n=0, busy=0, done=0, checksum_err=0, byte_cnt=0, word_cnt=0.
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE: byte_ready=0; core_rst_n=0.
  - start=1 -> COLLECT; byte_cnt and word_cnt cleared.
- COLLECT: byte_ready=1.
  - Transfer occurs only when byte_valid and byte_ready are both high.
  - Byte k (k=byte_cnt) goes to imem_wdata[8k+7:8k]; byte_cnt increments.
  - Transfer with byte_cnt=3 -> WRITE next cycle; byte_cnt wraps to 0.
  - byte_valid low: hold state; no bytes are lost or duplicated.
- WRITE: exactly one cycle.
  - imem_we=1, imem_addr=BASE_ADDR + 4*word_cnt, byte_ready=0.
  - imem_we rises the cycle after the 4th byte handshake.
  - word_cnt == NUM_WORDS-1 -> DONE; else word_cnt++ and -> COLLECT.
- Throughput: 5 cycles per word minimum.
- DONE: done=1, core_rst_n=1, byte_ready=0.
  - Extra byte_valid is ignored and never accepted.
  - start=1 -> COLLECT; core_rst_n drops to 0 on the same edge; done clears; counters clear.
- start while busy: ignored. A load cannot be aborted except by rst_n.
- rst_n asserted mid-load: immediate return to IDLE with reset values. The partial image is not rolled back; the core stays in reset.
- Address arithmetic is 32-bit unsigned; wrap past 2^32 is not supported.
- imem_addr and imem_wdata are registered. Outside WRITE they hold their last value.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A 32-bit running sum (mod 2^32) of all written words is kept.
  - After the last WRITE, the FSM enters extra state CHECK instead of DONE.
  - CHECK collects 4 more bytes little-endian (byte_ready=1), then goes to DONE.
  - Mismatch: checksum_err=1 and core_rst_n stays 0 in DONE.
  - Match: checksum_err=0 and core_rst_n=1.
  - Sum and checksum_err clear on start and on reset.
- Undefined: no CHECK state and no summing logic; checksum_err tied 0.

Test Plan:
1. Reset then start, NUM_WORDS=2, bytes 13 00 00 00 93 00 10 00 -> imem_we pulses with (addr 0x0, data 0x00000013) then (0x4, 0x00100093); done=1 and core_rst_n=1 one cycle after second write.
2. Valid gaps: byte_valid toggles every other cycle for the same image -> identical writes; no extra imem_we pulses; byte_ready=0 in WRITE cycles.
3. rst_n low after 5 bytes of a 2-word load -> all outputs at reset values within the same cycle; fresh start reloads correctly with word_cnt from 0.
4. start pulse in COLLECT -> ignored; word_cnt unchanged. Second start in DONE -> core_rst_n=0 next edge; reload begins at BASE_ADDR.
5. BASE_ADDR=32'h100, NUM_WORDS=1, bytes AA BB CC DD -> single write addr 0x100, data 0xDDCCBBAA.
6. IMEM_LOADER_CHECKSUM_EN defined, words 0x1 and 0x2:
   - Checksum bytes 03 00 00 00 -> checksum_err=0, core_rst_n=1.
   - Checksum bytes 04 00 00 00 -> checksum_err=1, core_rst_n=0.
